// File: rtl/dbf_ctrl_pkg.sv
// Shared DBF control definitions: sequencer state encoding and default window lengths.
// dbf_ch* and param.h consumers pull window lengths from here so they stay consistent.
package dbf_ctrl_pkg;

    localparam int STATE_WD = 3;

    typedef enum logic [STATE_WD-1:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_TX   = 3'd2,
        ST_RX   = 3'd3,
        ST_DONE = 3'd4
    } dbf_state_e;

    localparam int ADDR_WD_DEF    = 10;
    localparam int LUT_DEPTH_DEF  = 1024;
    localparam int TX_CYCLES_DEF  = 64;
    localparam int RX_SAMPLES_DEF = 4096;
    localparam int ZONE_LEN_DEF   = 16;
    localparam int CNT_WD_DEF     = 16;

endpackage

// File: rtl/dbf_line_seq_if.sv
// Host/channel-bank bus of the line sequencer: line control, LUT load handshake, window strobes.
interface dbf_line_seq_if
    import dbf_ctrl_pkg::*;
#(
    parameter int ADDR_WD = ADDR_WD_DEF
);
    logic               line_req;
    logic               lut_load_req;
    logic               lut_wr_valid;
    logic               lut_wr_ready;
    logic               abort;
    logic [ADDR_WD-1:0] dbf_lut_addr;
    logic               dbf_lut_we;
    logic               tx_en;
    logic               start;
    logic               line_busy;
    logic               line_done;

    modport master (
        input  line_req, lut_load_req, lut_wr_valid, abort,
        output lut_wr_ready, dbf_lut_addr, dbf_lut_we, tx_en, start, line_busy, line_done
    );

    modport slave (
        output line_req, lut_load_req, lut_wr_valid, abort,
        input  lut_wr_ready, dbf_lut_addr, dbf_lut_we, tx_en, start, line_busy, line_done
    );
endinterface

// File: rtl/dbf_zone_addr_gen.sv
// Zone counter with a saturating LUT address; ZONE_LEN=1 turns it into a plain write counter.
module dbf_zone_addr_gen
    import dbf_ctrl_pkg::*;
#(
    parameter int ADDR_WD   = ADDR_WD_DEF,
    parameter int CNT_WD    = CNT_WD_DEF,
    parameter int LUT_DEPTH = LUT_DEPTH_DEF,
    parameter int ZONE_LEN  = ZONE_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    output logic [ADDR_WD-1:0] addr
);
    localparam logic [ADDR_WD-1:0] ADDR_MAX = ADDR_WD'(LUT_DEPTH - 1);
    localparam logic [CNT_WD-1:0]  ZONE_MAX = CNT_WD'(ZONE_LEN - 1);

    logic [CNT_WD-1:0]  zone_q, zone_d;
    logic [ADDR_WD-1:0] addr_q, addr_d;

    always_comb begin
        zone_d = zone_q;
        addr_d = addr_q;
        if (clr) begin
            zone_d = '0;
            addr_d = '0;
        end else if (en) begin
            if (zone_q == ZONE_MAX) begin
                zone_d = '0;
                // Hold on the last entry instead of wrapping back to the near field.
                if (addr_q != ADDR_MAX) addr_d = addr_q + 1'b1;
            end else begin
                zone_d = zone_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            zone_q <= '0;
            addr_q <= '0;
        end else begin
            zone_q <= zone_d;
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;
endmodule

// File: rtl/dbf_line_seq.sv
// Per-scan-line sequencer: optional LUT load, transmit window, then receive window with
// dynamic-focus LUT address stepping. Drives the bus shared by all dbf_ch* channels.
module dbf_line_seq
    import dbf_ctrl_pkg::*;
#(
    parameter int ADDR_WD    = ADDR_WD_DEF,
    parameter int LUT_DEPTH  = LUT_DEPTH_DEF,
    parameter int TX_CYCLES  = TX_CYCLES_DEF,
    parameter int RX_SAMPLES = RX_SAMPLES_DEF,
    parameter int ZONE_LEN   = ZONE_LEN_DEF,
    parameter int CNT_WD     = CNT_WD_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    dbf_line_seq_if.master bus
);
    localparam logic [ADDR_WD-1:0] ADDR_MAX = ADDR_WD'(LUT_DEPTH - 1);
    localparam logic [CNT_WD-1:0]  TX_LAST  = CNT_WD'(TX_CYCLES - 1);
    localparam logic [CNT_WD-1:0]  RX_LAST  = CNT_WD'(RX_SAMPLES - 1);

    dbf_state_e         state_q, state_d;
    logic [CNT_WD-1:0]  cnt_q, cnt_d;
    logic               lut_we;
    logic               load_clr, rx_clr, rx_en;
    logic [ADDR_WD-1:0] load_addr, rx_addr;

    dbf_zone_addr_gen #(
        .ADDR_WD(ADDR_WD), .CNT_WD(CNT_WD), .LUT_DEPTH(LUT_DEPTH), .ZONE_LEN(1)
    ) u_load_addr (
        .clk(clk), .rst_n(rst_n), .clr(load_clr), .en(lut_we), .addr(load_addr)
    );

    dbf_zone_addr_gen #(
        .ADDR_WD(ADDR_WD), .CNT_WD(CNT_WD), .LUT_DEPTH(LUT_DEPTH), .ZONE_LEN(ZONE_LEN)
    ) u_rx_addr (
        .clk(clk), .rst_n(rst_n), .clr(rx_clr), .en(rx_en), .addr(rx_addr)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lut_we   = 1'b0;
        load_clr = 1'b1;
        rx_clr   = 1'b1;
        rx_en    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.line_req && !bus.abort)
                    state_d = bus.lut_load_req ? ST_LOAD : ST_TX;
            end
            ST_LOAD: begin
                load_clr = 1'b0;
                if (bus.abort) begin
                    load_clr = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    lut_we = bus.lut_wr_valid;
                    if (bus.lut_wr_valid && load_addr == ADDR_MAX) begin
                        load_clr = 1'b1;
                        state_d  = ST_TX;
                    end
                end
            end
            ST_TX: begin
                if (bus.abort) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == TX_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RX: begin
                rx_clr = bus.abort;
                rx_en  = !bus.abort;
                if (bus.abort) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == RX_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Window strobes decode registered state only; ready/we are the combinational handshake.
    assign bus.lut_wr_ready = (state_q == ST_LOAD);
    assign bus.dbf_lut_we   = lut_we;
    assign bus.tx_en        = (state_q == ST_TX);
    assign bus.start        = (state_q == ST_RX);
    assign bus.line_busy    = (state_q != ST_IDLE);
    assign bus.line_done    = (state_q == ST_DONE);
    assign bus.dbf_lut_addr = (state_q == ST_LOAD) ? load_addr :
                              (state_q == ST_RX)   ? rx_addr   : '0;
endmodule

// File: tb/tb_dbf_line_seq.sv
// Randomized scoreboard bench for dbf_line_seq: two instances (RX_SAMPLES 8 and 12).
module tb_dbf_line_seq;
    import dbf_ctrl_pkg::*;

    localparam int AW = 10, DEPTH = 4, TXC = 3, ZL = 2;

    typedef struct {
        logic          sel;
        logic          rst;
        logic          req, lreq, vld, abrt;
        logic [AW+5:0] exp;
    } cyc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, sel, req, lreq, vld, abrt;
    int   n_tests = 0, n_fail = 0;
    cyc_t stim_q[$];
    cyc_t sb_q[$];

    dbf_line_seq_if #(.ADDR_WD(AW)) ifa ();
    dbf_line_seq_if #(.ADDR_WD(AW)) ifb ();

    assign ifa.line_req     = req  & ~sel;
    assign ifa.lut_load_req = lreq & ~sel;
    assign ifa.lut_wr_valid = vld  & ~sel;
    assign ifa.abort        = abrt & ~sel;
    assign ifb.line_req     = req  & sel;
    assign ifb.lut_load_req = lreq & sel;
    assign ifb.lut_wr_valid = vld  & sel;
    assign ifb.abort        = abrt & sel;

    dbf_line_seq #(.ADDR_WD(AW), .LUT_DEPTH(DEPTH), .TX_CYCLES(TXC), .RX_SAMPLES(8),
                   .ZONE_LEN(ZL), .CNT_WD(16))
        u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.master));

    dbf_line_seq #(.ADDR_WD(AW), .LUT_DEPTH(DEPTH), .TX_CYCLES(TXC), .RX_SAMPLES(12),
                   .ZONE_LEN(ZL), .CNT_WD(16))
        u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.master));

    wire [AW+5:0] obs_a = {ifa.dbf_lut_addr, ifa.dbf_lut_we, ifa.lut_wr_ready, ifa.tx_en,
                           ifa.start, ifa.line_busy, ifa.line_done};
    wire [AW+5:0] obs_b = {ifb.dbf_lut_addr, ifb.dbf_lut_we, ifb.lut_wr_ready, ifb.tx_en,
                           ifb.start, ifb.line_busy, ifb.line_done};

    // Packed expectation: {addr, we, ready, tx_en, start, busy, done}; we is bit 5.
    function automatic logic [AW+5:0] pk(input int addr, input bit we, input bit rdy,
                                         input bit tx, input bit st, input bit bsy,
                                         input bit dn);
        return {AW'(addr), we, rdy, tx, st, bsy, dn};
    endfunction

    function automatic cyc_t idle_rec(input bit s);
        cyc_t r;
        r.sel = s; r.rst = 1'b0; r.req = 1'b0; r.abrt = 1'b0;
        r.lreq = 1'($urandom_range(0, 1));
        r.vld  = 1'($urandom_range(0, 1));
        r.exp  = pk(0, 0, 0, 0, 0, 0, 0);
        return r;
    endfunction

    function automatic cyc_t busy_rec(input bit s, input bit hold);
        cyc_t r;
        r = idle_rec(s);
        r.req = hold ? 1'b1 : 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Idle cycles; some carry line_req together with abort, which must not start a line.
    task automatic add_gap(input bit s, input int n);
        cyc_t r;
        for (int i = 0; i < n; i++) begin
            r = idle_rec(s);
            if ($urandom_range(0, 3) == 0) begin
                r.req  = 1'b1;
                r.abrt = 1'b1;
            end
            stim_q.push_back(r);
        end
    endtask

    // One scan line from the request cycle onward. abort_at/rst_at index the busy cycles
    // (-1 none, -2 abort at a random point with some probability).
    task automatic add_line(input bit s, input bit load, input int abort_at, input int rst_at,
                            input bit hold, input bit [15:0] pat, input int plen);
        cyc_t b[$];
        cyc_t r;
        int   acc, idx, rx, a, cut, ab;
        bit   v;
        rx = s ? 12 : 8;
        r = idle_rec(s);
        r.req = 1'b1; r.lreq = load;
        stim_q.push_back(r);
        if (load) begin
            acc = 0; idx = 0;
            while (acc < DEPTH) begin
                r = busy_rec(s, hold);
                v = (idx < plen) ? pat[idx] : ($urandom_range(0, 2) != 0);
                r.vld = v;
                r.exp = pk(acc, v, 1, 0, 0, 1, 0);
                if (v) acc++;
                idx++;
                b.push_back(r);
            end
        end
        for (int k = 0; k < TXC; k++) begin
            r = busy_rec(s, hold);
            r.exp = pk(0, 0, 0, 1, 0, 1, 0);
            b.push_back(r);
        end
        for (int k = 0; k < rx; k++) begin
            r = busy_rec(s, hold);
            a = k / ZL;
            if (a > DEPTH - 1) a = DEPTH - 1;
            r.exp = pk(a, 0, 0, 0, 1, 1, 0);
            b.push_back(r);
        end
        r = busy_rec(s, hold);
        r.exp = pk(0, 0, 0, 0, 0, 1, 1);
        b.push_back(r);
        cut = b.size();
        ab  = abort_at;
        if (ab == -2) ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, b.size() - 2) : -1;
        if (ab >= 0) begin
            b[ab].abrt   = 1'b1;
            b[ab].exp[5] = 1'b0;
            cut = ab + 1;
        end
        if (rst_at >= 0) begin
            b[rst_at].rst    = 1'b1;
            b[rst_at].vld    = 1'b0;
            b[rst_at].exp[5] = 1'b0;
            cut = rst_at + 1;
        end
        for (int k = 0; k < cut; k++) stim_q.push_back(b[k]);
    endtask

    always @(negedge clk) begin
        cyc_t r;
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            n_tests++;
            if ((r.sel ? obs_b : obs_a) !== r.exp) begin
                n_fail++;
                $display("FAIL outputs dut=%0d t=%0t got=%h exp=%h (addr,we,rdy,tx,st,busy,done)",
                         r.sel, $time, r.sel ? obs_b : obs_a, r.exp);
            end
            n_tests++;
            if ((r.sel ? obs_a : obs_b) !== '0) begin
                n_fail++;
                $display("FAIL idle_dut dut=%0d t=%0t got=%h exp=0",
                         !r.sel, $time, r.sel ? obs_a : obs_b);
            end
        end
    end

    initial begin
        cyc_t r;
        int   w;
        rst_n = 1'b1; sel = 1'b0; req = 1'b0; lreq = 1'b0; vld = 1'b0; abrt = 1'b0;

        add_gap(0, 3);
        add_line(0, 0, -1, -1, 0, 16'h0, 0);
        add_gap(0, 2);
        add_line(0, 1, -1, -1, 0, 16'b101101, 6);
        add_gap(1, 1);
        add_line(1, 0, -1, -1, 0, 16'h0, 0);
        add_gap(1, 1);
        add_line(1, 1, -1, -1, 0, 16'h0, 0);
        add_gap(0, 1);
        add_line(0, 0, TXC + 3, -1, 0, 16'h0, 0);
        add_line(0, 0, -1, -1, 0, 16'h0, 0);
        add_gap(0, 1);
        add_line(0, 0, -1, -1, 1, 16'h0, 0);
        add_line(0, 1, -1, -1, 1, 16'h0, 0);
        add_gap(0, 1);
        add_line(0, 1, -1, 2, 0, 16'hffff, 16);
        add_gap(0, 2);
        for (int n = 0; n < 40; n++) begin
            bit s;
            s = 1'($urandom_range(0, 1));
            add_line(s, 1'($urandom_range(0, 1)), -2, -1, ($urandom_range(0, 3) == 0),
                     16'h0, 0);
            add_gap(s, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        while (stim_q.size() > 0) begin
            r = stim_q.pop_front();
            sel = r.sel; rst_n = r.rst; req = r.req; lreq = r.lreq; vld = r.vld; abrt = r.abrt;
            sb_q.push_back(r);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0; req = 1'b0; vld = 1'b0; abrt = 1'b0;
        w = 0;
        while (sb_q.size() > 0 && w < 10) begin
            @(posedge clk);
            w++;
        end
        n_tests++;
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d exp=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
